// File: rtl/stepper_ramp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_ramp_pkg
//  Description : Shared definitions for the stepper ramp stage and its driver:
//                state codes, command-word field positions, default period
//                limits and the period arithmetic helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package stepper_ramp_pkg;

    // Command word field positions (same layout on data_in and cmd_out)
    localparam int unsigned PERIOD_LSB = 0;
    localparam int unsigned PERIOD_MSB = 21;
    localparam int unsigned EN_A       = 22;
    localparam int unsigned EN_B       = 23;

    // Default half-period limits, shared with the driver
    localparam int unsigned DEF_PERIOD_MIN = 263_158;    // about 190 Hz
    localparam int unsigned DEF_PERIOD_MAX = 1_000_000;  // 50 Hz, start/stop speed

    // State codes, also reported in status[31:29]
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_RAMP  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Force a requested half-period into the legal window
    function automatic logic [21:0] clamp_period(input logic [21:0] val,
                                                 input logic [21:0] lo,
                                                 input logic [21:0] hi);
        logic [21:0] res;
        if (val < lo)
            res = lo;
        else if (val > hi)
            res = hi;
        else
            res = val;
        return res;
    endfunction

    // One ramp step from cur toward tgt; snaps onto tgt when within one step.
    // Done at 23 bits so cur + step can never wrap.
    function automatic logic [21:0] step_toward(input logic [21:0] cur,
                                                input logic [21:0] tgt,
                                                input logic [22:0] step);
        logic [22:0] c;
        logic [22:0] t;
        logic [21:0] res;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c > t)
            res = ((c - t) <= step) ? tgt : 22'(c - step);
        else
            res = ((t - c) <= step) ? tgt : 22'(c + step);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_ramp_tick.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_ramp_tick
//  Description : Ramp update divider. Counts 0..UPDATE_CYCLES-1 while run is
//                high and flags the last count as the update tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_ramp_tick
    import stepper_ramp_pkg::*;
#(
    parameter int unsigned UPDATE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned      c_cnt_w = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(UPDATE_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Free-running divider, parked at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clear)
            r_cnt <= '0;
        else if (run)
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
    end

    assign tick = run && !clear && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/stepper_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_ramp
//  Description : Motion-profile stage ahead of the stepper driver. Accepts
//                target speed/enable writes and emits command words whose
//                half-period ramps toward the target once per update tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_ramp
    import stepper_ramp_pkg::*;
#(
    parameter int unsigned UPDATE_CYCLES = 1_000_000,
    parameter int unsigned STEP          = 10_000,
    parameter int unsigned PERIOD_MIN    = DEF_PERIOD_MIN,
    parameter int unsigned PERIOD_MAX    = DEF_PERIOD_MAX
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        wr_en,
    output logic [31:0] cmd_out,
    output logic        cmd_valid,
    output logic        busy,
    output logic [31:0] status
);

    localparam logic [21:0] c_pmin = 22'(PERIOD_MIN);
    localparam logic [21:0] c_pmax = 22'(PERIOD_MAX);
    localparam logic [22:0] c_step = 23'(STEP);

    logic [2:0]  r_state;
    logic [21:0] r_target_period;
    logic [1:0]  r_target_en;
    logic [21:0] r_cur_period;
    logic [1:0]  r_cur_en;
    logic [31:0] r_cmd_out;
    logic        r_cmd_valid;
    logic        r_boot;

    logic [2:0]  w_state_nxt;
    logic [21:0] w_cur_period_nxt;
    logic [1:0]  w_cur_en_nxt;
    logic        w_emit;
    logic        w_tick;
    logic        w_run;
    logic        w_clear;
    logic [21:0] w_wr_period;
    logic [1:0]  w_wr_en;
    logic        w_unused_bits;

    assign w_wr_period   = clamp_period(data_in[PERIOD_MSB:PERIOD_LSB], c_pmin, c_pmax);
    assign w_wr_en       = {data_in[EN_B], data_in[EN_A]};
    assign w_unused_bits = &{1'b0, data_in[31:24]};

    // Divider runs outside IDLE and restarts on every START
    assign w_run   = (r_state != ST_IDLE);
    assign w_clear = (r_state == ST_IDLE) || (r_state == ST_START);

    stepper_ramp_tick #(
        .UPDATE_CYCLES (UPDATE_CYCLES)
    ) u_tick (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .clear (w_clear),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Next state, next current period/enables and emit request
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_period_nxt = r_cur_period;
        w_cur_en_nxt     = r_cur_en;
        w_emit           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cur_period_nxt = c_pmax;
                w_cur_en_nxt     = 2'b00;
                if (wr_en && (w_wr_en != 2'b00)) begin
                    w_state_nxt  = ST_START;
                    w_cur_en_nxt = w_wr_en;
                    w_emit       = 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt  = ST_RAMP;
                w_cur_en_nxt = r_target_en;
                if (wr_en) begin
                    if (w_wr_en == 2'b00) begin
                        w_state_nxt = ST_STOP;
                    end else if (w_wr_en != r_cur_en) begin
                        w_cur_en_nxt = w_wr_en;
                        w_emit       = 1'b1;
                    end
                end
            end
            ST_RAMP, ST_HOLD: begin
                // The tick steps toward the target held before any same-cycle write
                if ((r_state == ST_RAMP) && w_tick) begin
                    w_cur_period_nxt = step_toward(r_cur_period, r_target_period, c_step);
                    w_emit           = 1'b1;
                    if (w_cur_period_nxt == r_target_period)
                        w_state_nxt = ST_HOLD;
                end
                if (wr_en) begin
                    if (w_wr_en == 2'b00) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        if (w_wr_en != r_cur_en) begin
                            w_cur_en_nxt = w_wr_en;
                            w_emit       = 1'b1;
                        end
                        w_state_nxt = (w_cur_period_nxt == w_wr_period) ? ST_HOLD : ST_RAMP;
                    end
                end
            end
            ST_STOP: begin
                // Ramp out to the slowest speed, then drop the coils one tick later
                if (w_tick) begin
                    w_emit = 1'b1;
                    if (r_cur_period == c_pmax) begin
                        w_cur_en_nxt = 2'b00;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_cur_period_nxt = step_toward(r_cur_period, c_pmax, c_step);
                    end
                end
                if (wr_en && (w_wr_en != 2'b00)) begin
                    w_state_nxt  = ST_RAMP;
                    w_cur_en_nxt = w_wr_en;
                    if (w_wr_en != r_cur_en)
                        w_emit = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, target and command registers; one pulse after reset wakes the driver
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_target_period <= c_pmax;
            r_target_en     <= 2'b00;
            r_cur_period    <= c_pmax;
            r_cur_en        <= 2'b00;
            r_cmd_out       <= {8'h00, 2'b00, c_pmax};
            r_cmd_valid     <= 1'b0;
            r_boot          <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_period <= w_cur_period_nxt;
            r_cur_en     <= w_cur_en_nxt;
            r_boot       <= 1'b0;
            if (wr_en) begin
                r_target_period <= w_wr_period;
                r_target_en     <= w_wr_en;
            end
            if (w_emit) begin
                r_cmd_out   <= {8'h00, w_cur_en_nxt, w_cur_period_nxt};
                r_cmd_valid <= 1'b1;
            end else begin
                r_cmd_valid <= r_boot;
            end
        end
    end

    assign cmd_out   = r_cmd_out;
    assign cmd_valid = r_cmd_valid;
    assign busy      = (r_state == ST_START) || (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign status    = {r_state, busy, 4'b0000, r_cur_en, r_cur_period};

endmodule
`default_nettype wire

// File: tb/tb_stepper_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_ramp
//  Description : Directed self-checking bench for stepper_ramp with a short
//                update interval and a large step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_ramp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        wr_en = 1'b0;
    logic [31:0] cmd_out;
    logic        cmd_valid;
    logic        busy;
    logic [31:0] status;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stepper_ramp #(
        .UPDATE_CYCLES (4),
        .STEP          (100_000)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .status    (status)
    );

    // One-cycle write; returns on the falling edge after the sampling edge
    task automatic wr(input logic [31:0] d);
        data_in = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Waits up to max_cyc falling edges for a pulse; cyc = 0 on timeout
    task automatic wait_pulse(input int max_cyc, output int cyc, output logic [31:0] word);
        logic done;
        done = 1'b0;
        cyc  = 0;
        word = '0;
        for (int i = 1; i <= max_cyc; i++) begin
            if (!done) begin
                @(negedge clk);
                if (cmd_valid === 1'b1) begin
                    cyc  = i;
                    word = cmd_out;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({cmd_valid, busy, cmd_out} !== {1'b0, 1'b0, 32'h000F_4240})
            $display("FAIL reset_outputs: got valid=%b busy=%b cmd=%h, expected valid=0 busy=0 cmd=000f4240",
                     cmd_valid, busy, cmd_out);
        else n_pass++;
        n_total++;
        if (status !== 32'h000F_4240)
            $display("FAIL reset_status: got %h, expected 000f4240", status);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h000F_4240})
            $display("FAIL boot_pulse: got valid=%b cmd=%h, expected valid=1 cmd=000f4240", cmd_valid, cmd_out);
        else n_pass++;
        count_pulses(10, cnt);
        n_total++;
        if (cnt !== 0)
            $display("FAIL idle_quiet: got %0d extra pulses, expected 0", cnt);
        else n_pass++;
    endtask

    task automatic test_start();
        int          periods [8];
        int          cyc;
        int          want_cyc;
        int          cnt;
        logic [31:0] word;
        logic [31:0] exp_word;
        periods = '{900_000, 800_000, 700_000, 600_000, 500_000, 400_000, 300_000, 263_158};
        wr(32'h00C4_0000);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h00CF_4240})
            $display("FAIL start_pulse: got valid=%b cmd=%h, expected valid=1 cmd=00cf4240", cmd_valid, cmd_out);
        else n_pass++;
        n_total++;
        if ({status[31:29], busy} !== {3'd1, 1'b1})
            $display("FAIL start_state: got state=%0d busy=%b, expected state=1 busy=1", status[31:29], busy);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            want_cyc = (i == 0) ? 5 : 4;
            exp_word = 32'h00C0_0000 | 32'(periods[i]);
            wait_pulse(want_cyc + 2, cyc, word);
            n_total++;
            if (cyc !== want_cyc || word !== exp_word)
                $display("FAIL accel_%0d: got %h after %0d cycles, expected %h after %0d cycles",
                         i, word, cyc, exp_word, want_cyc);
            else n_pass++;
        end
        n_total++;
        if ({status[31:29], busy, status[21:0]} !== {3'd3, 1'b0, 22'd263_158})
            $display("FAIL hold_reached: got state=%0d busy=%b period=%0d, expected state=3 busy=0 period=263158",
                     status[31:29], busy, status[21:0]);
        else n_pass++;
        count_pulses(12, cnt);
        n_total++;
        if (cnt !== 0)
            $display("FAIL hold_quiet: got %0d pulses, expected 0", cnt);
        else n_pass++;
    endtask

    task automatic test_stop_from_hold();
        int          periods [8];
        int          cyc;
        int          cnt;
        logic [31:0] word;
        logic [31:0] exp_word;
        periods = '{363_158, 463_158, 563_158, 663_158, 763_158, 863_158, 963_158, 1_000_000};
        wr(32'h0000_0000);
        n_total++;
        if ({status[31:29], busy} !== {3'd4, 1'b1})
            $display("FAIL stop_state: got state=%0d busy=%b, expected state=4 busy=1", status[31:29], busy);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_word = 32'h00C0_0000 | 32'(periods[i]);
            wait_pulse(6, cyc, word);
            n_total++;
            if (cyc < 1 || (i > 0 && cyc !== 4) || word !== exp_word)
                $display("FAIL decel_%0d: got %h after %0d cycles, expected %h", i, word, cyc, exp_word);
            else n_pass++;
        end
        wait_pulse(6, cyc, word);
        n_total++;
        if (cyc !== 4 || word !== 32'h000F_4240)
            $display("FAIL stop_final: got %h after %0d cycles, expected 000f4240 after 4 cycles", word, cyc);
        else n_pass++;
        n_total++;
        if ({status, busy} !== {32'h000F_4240, 1'b0})
            $display("FAIL stop_idle: got status=%h busy=%b, expected status=000f4240 busy=0", status, busy);
        else n_pass++;
        count_pulses(10, cnt);
        n_total++;
        if (cnt !== 0)
            $display("FAIL stop_quiet: got %0d pulses, expected 0", cnt);
        else n_pass++;
    endtask

    task automatic test_clamp_high();
        int          cyc;
        int          cnt;
        logic [31:0] word;
        wr(32'h00FF_FFFF);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h00CF_4240})
            $display("FAIL clamp_start: got valid=%b cmd=%h, expected valid=1 cmd=00cf4240", cmd_valid, cmd_out);
        else n_pass++;
        wait_pulse(7, cyc, word);
        n_total++;
        if (cyc !== 5 || word !== 32'h00CF_4240 || status[31:29] !== 3'd3)
            $display("FAIL clamp_hold: got %h after %0d cycles state=%0d, expected 00cf4240 after 5 cycles state=3",
                     word, cyc, status[31:29]);
        else n_pass++;
        count_pulses(8, cnt);
        n_total++;
        if (cnt !== 0)
            $display("FAIL clamp_quiet: got %0d pulses, expected 0", cnt);
        else n_pass++;
    endtask

    task automatic test_enable_change();
        int          cyc;
        logic [31:0] word;
        wr(32'h0040_0000);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h004F_4240})
            $display("FAIL en_change_pulse: got valid=%b cmd=%h, expected valid=1 cmd=004f4240", cmd_valid, cmd_out);
        else n_pass++;
        n_total++;
        if ({status[31:29], status[23:22]} !== {3'd2, 2'b01})
            $display("FAIL en_change_state: got state=%0d en=%b, expected state=2 en=01", status[31:29], status[23:22]);
        else n_pass++;
        wait_pulse(5, cyc, word);
        n_total++;
        if (cyc < 1 || word !== 32'h004D_BBA0)
            $display("FAIL en_ramp_0: got %h after %0d cycles, expected 004dbba0", word, cyc);
        else n_pass++;
        wait_pulse(6, cyc, word);
        n_total++;
        if (cyc !== 4 || word !== 32'h004C_3500)
            $display("FAIL en_ramp_1: got %h after %0d cycles, expected 004c3500 after 4 cycles", word, cyc);
        else n_pass++;
    endtask

    // Arrives right after a tick pulse, so the tick falls three edges later
    task automatic test_write_with_tick();
        int          cyc;
        logic [31:0] word;
        repeat (3) @(negedge clk);
        wr(32'h008B_71B0);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h008A_AE60})
            $display("FAIL coincident_emit: got valid=%b cmd=%h, expected valid=1 cmd=008aae60", cmd_valid, cmd_out);
        else n_pass++;
        n_total++;
        if (status[31:29] !== 3'd2)
            $display("FAIL coincident_state: got state=%0d, expected 2", status[31:29]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cmd_valid !== 1'b0)
            $display("FAIL coincident_single: got valid=%b, expected 0", cmd_valid);
        else n_pass++;
        wait_pulse(5, cyc, word);
        n_total++;
        if (cyc < 1 || word !== 32'h008B_71B0 || status[31:29] !== 3'd3)
            $display("FAIL new_target_hold: got %h after %0d cycles state=%0d, expected 008b71b0 state=3",
                     word, cyc, status[31:29]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ramp();
        int          cyc;
        logic [31:0] word;
        wr(32'h00C4_03F6);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h00CB_71B0})
            $display("FAIL mid_en_pulse: got valid=%b cmd=%h, expected valid=1 cmd=00cb71b0", cmd_valid, cmd_out);
        else n_pass++;
        wait_pulse(5, cyc, word);
        n_total++;
        if (cyc < 1 || word !== 32'h00C9_EB10)
            $display("FAIL mid_ramp_step: got %h after %0d cycles, expected 00c9eb10", word, cyc);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({cmd_valid, busy, cmd_out, status} !== {1'b0, 1'b0, 32'h000F_4240, 32'h000F_4240})
            $display("FAIL mid_reset: got valid=%b busy=%b cmd=%h status=%h, expected 0 0 000f4240 000f4240",
                     cmd_valid, busy, cmd_out, status);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({cmd_valid, cmd_out} !== {1'b1, 32'h000F_4240})
            $display("FAIL mid_boot_pulse: got valid=%b cmd=%h, expected valid=1 cmd=000f4240", cmd_valid, cmd_out);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cmd_valid !== 1'b0)
            $display("FAIL mid_boot_single: got valid=%b, expected 0", cmd_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop_from_hold();
        test_clamp_high();
        test_enable_change();
        test_write_with_tick();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
